// File: rtl/voice_mix_scheduler.sv
// ---------------------------------------------------------------------------
// voice_mix_scheduler
//
// Purpose:
//   On every rising edge of the I2S frame clock it walks every active voice
//   in index order through one shared sample-compute datapath. It sums the
//   returned samples, scales the sum by an arithmetic right shift, saturates
//   it to 16 bits and pushes one word into the audio FIFO.
//
// Ports:
//   clk_i            system clock, all logic on the rising edge
//   reset_n_i        synchronous active-low reset
//   lrclk_i          I2S frame clock, asynchronous to clk_i
//   voice_active_i   per-voice enable, sampled when that voice is issued
//   voice_sel_o      index of the voice being requested
//   voice_req_o      one-cycle request strobe to the voice datapath
//   voice_ack_i      datapath response valid (one cycle)
//   voice_sample_i   signed sample, valid with voice_ack_i
//   fifo_full_i      audio FIFO write-side full
//   fifo_write_o     FIFO write strobe
//   audio_out_o      signed mixed sample to the FIFO data input
//   busy_o           high whenever a frame is in progress
//   overrun_cnt_o    frames lost, saturates at 255
//   timeout_err_o    sticky flag: some voice never answered in time
// ---------------------------------------------------------------------------
module voice_mix_scheduler #(
    parameter int NUM_VOICES  = 8,
    parameter int GAIN_SHIFT  = 3,
    parameter int ACK_TIMEOUT = 64,
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  lrclk_i,
    input  logic [NUM_VOICES-1:0] voice_active_i,
    output logic [VW-1:0]         voice_sel_o,
    output logic                  voice_req_o,
    input  logic                  voice_ack_i,
    input  logic [15:0]           voice_sample_i,
    input  logic                  fifo_full_i,
    output logic                  fifo_write_o,
    output logic [15:0]           audio_out_o,
    output logic                  busy_o,
    output logic [7:0]            overrun_cnt_o,
    output logic                  timeout_err_o
);

    // The accumulator is wide enough to hold NUM_VOICES full-scale samples.
    localparam int AW = 16 + VW;
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic signed [AW-1:0] SAT_MAX = AW'(32767);
    localparam logic signed [AW-1:0] SAT_MIN = AW'(-32768);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_NEXT,
        S_SCALE,
        S_WRITE
    } state_t;

    state_t                state_q;
    logic [VW-1:0]         idx_q;
    logic signed [AW-1:0]  acc_q;
    logic [TW-1:0]         timer_q;
    logic                  tick_pend_q;
    logic [15:0]           audio_q;
    logic [7:0]            overrun_q;
    logic                  timeout_q;
    logic                  lrclk_s1_q;
    logic                  lrclk_s2_q;
    logic                  lrclk_s3_q;

    logic                  tick_d;
    logic                  busy_d;
    logic                  overrun_inc_d;
    logic signed [AW-1:0]  sample_ext_d;
    logic signed [AW-1:0]  acc_sh_d;
    logic [15:0]           sat_d;

    // Rising edge of the synchronised frame clock.
    assign tick_d = lrclk_s2_q & ~lrclk_s3_q;
    assign busy_d = (state_q != S_IDLE);

    // A tick arriving while one is already pending is lost. In WRITE with the
    // FIFO full the stalled sample is the one discarded instead, which is
    // still exactly one lost frame, so both cases share this increment.
    assign overrun_inc_d = tick_d & busy_d & tick_pend_q;

    assign sample_ext_d = AW'($signed(voice_sample_i));
    assign acc_sh_d     = acc_q >>> GAIN_SHIFT;

    always_comb begin
        sat_d = acc_sh_d[15:0];
        if (acc_sh_d > SAT_MAX) begin
            sat_d = 16'h7FFF;
        end else if (acc_sh_d < SAT_MIN) begin
            sat_d = 16'h8000;
        end
    end

    assign voice_sel_o   = idx_q;
    assign voice_req_o   = (state_q == S_ISSUE) & voice_active_i[idx_q];
    assign fifo_write_o  = (state_q == S_WRITE) & ~fifo_full_i;
    assign audio_out_o   = audio_q;
    assign busy_o        = busy_d;
    assign overrun_cnt_o = overrun_q;
    assign timeout_err_o = timeout_q;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            timer_q     <= '0;
            tick_pend_q <= 1'b0;
            audio_q     <= '0;
            overrun_q   <= '0;
            timeout_q   <= 1'b0;
            lrclk_s1_q  <= 1'b0;
            lrclk_s2_q  <= 1'b0;
            lrclk_s3_q  <= 1'b0;
        end else begin
            lrclk_s1_q <= lrclk_i;
            lrclk_s2_q <= lrclk_s1_q;
            lrclk_s3_q <= lrclk_s2_q;

            if (tick_d && busy_d && !tick_pend_q) begin
                tick_pend_q <= 1'b1;
            end
            if (overrun_inc_d && (overrun_q != 8'hFF)) begin
                overrun_q <= overrun_q + 8'd1;
            end

            case (state_q)
                S_IDLE: begin
                    if (tick_d || tick_pend_q) begin
                        acc_q       <= '0;
                        idx_q       <= '0;
                        // A fresh tick landing while a pending one is being
                        // consumed becomes the next pending frame.
                        tick_pend_q <= tick_d & tick_pend_q;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (voice_active_i[idx_q]) begin
                        timer_q <= '0;
                        state_q <= S_WAIT_ACK;
                    end else begin
                        state_q <= S_NEXT;
                    end
                end
                S_WAIT_ACK: begin
                    if (voice_ack_i) begin
                        acc_q   <= acc_q + sample_ext_d;
                        state_q <= S_NEXT;
                    end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_NEXT;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (idx_q == VW'(NUM_VOICES - 1)) begin
                        state_q <= S_SCALE;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_SCALE: begin
                    audio_q <= sat_d;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    if (!fifo_full_i) begin
                        state_q <= S_IDLE;
                    end else if (tick_d && tick_pend_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_mix_scheduler.sv
module tb_voice_mix_scheduler;

    localparam int NV = 4;
    localparam int GS = 1;
    localparam int AT = 64;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          lrclk = 1'b0;
    logic [NV-1:0] voice_active = '0;
    logic [1:0]    voice_sel;
    logic          voice_req;
    logic          voice_ack = 1'b0;
    logic [15:0]   voice_sample = '0;
    logic          fifo_full = 1'b0;
    logic          fifo_write;
    logic [15:0]   audio_out;
    logic          busy;
    logic [7:0]    overrun_cnt;
    logic          timeout_err;

    int tests_run = 0;
    int tests_failed = 0;

    // Voice datapath behaviour, set by the tests.
    int smp [NV];
    int lat [NV];
    bit noack [NV];

    int wr_cnt = 0;
    int got_q [$];
    int req_q [$];

    always #5 clk = ~clk;

    voice_mix_scheduler #(
        .NUM_VOICES (NV),
        .GAIN_SHIFT (GS),
        .ACK_TIMEOUT(AT)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .lrclk_i       (lrclk),
        .voice_active_i(voice_active),
        .voice_sel_o   (voice_sel),
        .voice_req_o   (voice_req),
        .voice_ack_i   (voice_ack),
        .voice_sample_i(voice_sample),
        .fifo_full_i   (fifo_full),
        .fifo_write_o  (fifo_write),
        .audio_out_o   (audio_out),
        .busy_o        (busy),
        .overrun_cnt_o (overrun_cnt),
        .timeout_err_o (timeout_err)
    );

    // Voice datapath model: answers a request lat[sel] cycles later.
    initial begin
        int resp_cnt;
        int resp_val;
        resp_cnt = 0;
        resp_val = 0;
        forever begin
            @(negedge clk);
            voice_ack = 1'b0;
            if (!reset_n) begin
                resp_cnt = 0;
            end else begin
                if (resp_cnt > 0) begin
                    resp_cnt--;
                    if (resp_cnt == 0) begin
                        voice_ack    = 1'b1;
                        voice_sample = 16'(resp_val);
                    end
                end
                if (voice_req && !noack[voice_sel]) begin
                    resp_cnt = lat[voice_sel];
                    resp_val = smp[voice_sel];
                end
            end
        end
    end

    // FIFO-side and request monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (voice_req) req_q.push_back(int'(voice_sel));
            if (fifo_write) begin
                wr_cnt++;
                got_q.push_back(int'($signed(audio_out)));
                $display("[TB] write #%0d audio=%0d overrun=%0d", wr_cnt, $signed(audio_out), overrun_cnt);
            end
        end
    end

    // Reference: sum of answered active voices, floor-shifted, clamped.
    function automatic int model_mix(input logic [NV-1:0] act);
        int s;
        s = 0;
        for (int i = 0; i < NV; i++) begin
            if (act[i] && !noack[i]) s += smp[i];
        end
        s = s >>> GS;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1 lrclk = 1'b1;
        repeat (4) @(negedge clk);
        #1 lrclk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_writes(input int target, input int bound, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            if (wr_cnt >= target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (wr_cnt >= target) ok = 1'b1;
    endtask

    task automatic set_all(input int value, input int l);
        for (int i = 0; i < NV; i++) begin
            smp[i] = value;
            lat[i] = l;
            noack[i] = 1'b0;
        end
    endtask

    // One frame: tick, wait for the write, compare against the model.
    task automatic run_frame(input string name);
        bit ok;
        int base;
        int exp_v;
        int got;
        exp_v = model_mix(voice_active);
        got_q.delete();
        base = wr_cnt;
        tick();
        wait_writes(base + 1, 400, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL %s_write: got %0d writes, need 1", name, wr_cnt - base);
        end else begin
            got = got_q.pop_front();
            tests_run++;
            if (got !== exp_v) begin
                tests_failed++;
                $display("FAIL %s_audio: got %0d, need %0d", name, got, exp_v);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if ({voice_req, fifo_write, busy, timeout_err} !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got req/wr/busy/to=%b, need 0000", {voice_req, fifo_write, busy, timeout_err});
        end
        tests_run++;
        if ({audio_out, overrun_cnt, voice_sel} !== 26'b0) begin
            tests_failed++;
            $display("FAIL reset_values: got audio=%0h ovr=%0d sel=%0d, need 0", audio_out, overrun_cnt, voice_sel);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // No active voices: tick-to-write latency is 2*NV+2 after the tick,
    // which itself appears two cycles after the LRCLK edge.
    task automatic test_latency();
        int n;
        int base;
        set_all(0, 1);
        voice_active = '0;
        got_q.delete();
        base = wr_cnt;
        @(negedge clk);
        lrclk = 1'b1;
        n = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            #1;
            n++;
            if (wr_cnt != base) break;
        end
        tests_run++;
        if (n !== 2 * NV + 4) begin
            tests_failed++;
            $display("FAIL latency: got %0d cycles, need %0d", n, 2 * NV + 4);
        end
        tests_run++;
        if (got_q.size() != 1 || got_q[0] !== 0) begin
            tests_failed++;
            $display("FAIL latency_audio: got %0d words, need one zero word", got_q.size());
        end
        lrclk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        set_all(1000, 3);
        voice_active = 4'b1111;
        run_frame("basic");
    endtask

    task automatic test_saturation();
        set_all(32767, 2);
        voice_active = 4'b1111;
        run_frame("sat_pos");
        set_all(-32768, 1);
        run_frame("sat_neg");
    endtask

    task automatic test_sparse();
        for (int i = 0; i < NV; i++) begin
            smp[i] = int'($urandom_range(0, 65535)) - 32768;
            lat[i] = 2;
            noack[i] = 1'b0;
        end
        voice_active = 4'b0101;
        req_q.delete();
        run_frame("sparse");
        tests_run++;
        if (req_q.size() != 2 || req_q[0] != 0 || req_q[1] != 2) begin
            tests_failed++;
            $display("FAIL sparse_req: got %0d requests (first=%0d), need sel 0 then 2",
                     req_q.size(), (req_q.size() > 0) ? req_q[0] : -1);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < NV; i++) begin
                smp[i] = int'($urandom_range(0, 65535)) - 32768;
                lat[i] = int'($urandom_range(1, 5));
                noack[i] = 1'b0;
            end
            voice_active = 4'($urandom_range(0, 15));
            run_frame("random");
        end
    endtask

    // Second tick during a frame is held pending and produces a second frame.
    task automatic test_back_to_back();
        bit ok;
        int base;
        int exp_v;
        set_all(0, 2);
        for (int i = 0; i < NV; i++) smp[i] = int'($urandom_range(0, 20000)) - 10000;
        voice_active = 4'b1111;
        exp_v = model_mix(voice_active);
        got_q.delete();
        base = wr_cnt;
        tick();
        tick();
        wait_writes(base + 2, 400, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL b2b_writes: got %0d writes, need 2", wr_cnt - base);
        end
        tests_run++;
        if (got_q.size() != 2 || got_q[0] !== exp_v || got_q[1] !== exp_v) begin
            tests_failed++;
            $display("FAIL b2b_audio: got %0d words, need two of %0d", got_q.size(), exp_v);
        end
        tests_run++;
        if (overrun_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL b2b_overrun: got %0d, need 0", overrun_cnt);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_overrun();
        bit ok;
        int base;
        int exp_v;
        set_all(500, 1);
        voice_active = 4'b1111;
        exp_v = model_mix(voice_active);
        got_q.delete();
        base = wr_cnt;
        fifo_full = 1'b1;
        tick();                 // frame runs and stalls in WRITE
        repeat (25) @(negedge clk);
        tick();                 // held as pending
        tick();                 // stalled sample dropped, pending frame starts
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (wr_cnt != base) begin
            tests_failed++;
            $display("FAIL overrun_nowrite: got %0d writes, need 0", wr_cnt - base);
        end
        tests_run++;
        if (overrun_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL overrun_cnt: got %0d, need 1", overrun_cnt);
        end
        fifo_full = 1'b0;
        wait_writes(base + 1, 200, ok);
        tests_run++;
        if (!ok || got_q.size() == 0 || got_q[0] !== exp_v) begin
            tests_failed++;
            $display("FAIL overrun_release: got %0d words, need one of %0d", got_q.size(), exp_v);
        end
        repeat (4) @(negedge clk);
        #1;
        tests_run++;
        if (overrun_cnt !== 8'd1 || wr_cnt != base + 1) begin
            tests_failed++;
            $display("FAIL overrun_after: got cnt=%0d writes=%0d, need 1 and 1", overrun_cnt, wr_cnt - base);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        bit seen;
        int k;
        int base;
        int exp_v;
        set_all(1200, 1);
        noack[1] = 1'b1;
        voice_active = 4'b1111;
        exp_v = model_mix(voice_active);
        tests_run++;
        if (timeout_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_pre: got %b, need 0", timeout_err);
        end
        got_q.delete();
        base = wr_cnt;
        @(negedge clk);
        #1 lrclk = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            #1;
            if (voice_req && voice_sel == 2'd1) begin
                seen = 1'b1;
                break;
            end
        end
        lrclk = 1'b0;
        k = 0;
        for (int c = 0; c < 200 && seen; c++) begin
            @(negedge clk);
            #1;
            k++;
            if (timeout_err) break;
        end
        tests_run++;
        if (!seen || k !== AT + 1) begin
            tests_failed++;
            $display("FAIL timeout_time: got flag %0d cycles after request, need %0d", k, AT + 1);
        end
        wait_writes(base + 1, 200, ok);
        tests_run++;
        if (!ok || got_q.size() == 0 || got_q[0] !== exp_v) begin
            tests_failed++;
            $display("FAIL timeout_audio: got %0d words, need one of %0d", got_q.size(), exp_v);
        end
        noack[1] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit seen;
        bit ok;
        int base;
        set_all(700, 10);
        voice_active = 4'b1111;
        base = wr_cnt;
        @(negedge clk);
        #1 lrclk = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            #1;
            if (voice_req) begin
                seen = 1'b1;
                break;
            end
        end
        lrclk = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if (!seen || !busy) begin
            tests_failed++;
            $display("FAIL midreset_setup: got req=%b busy=%b, need 1 1", seen, busy);
        end
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        if ({voice_req, fifo_write, busy, timeout_err, overrun_cnt, audio_out, voice_sel} !== 30'b0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got busy=%b to=%b ovr=%0d audio=%0h sel=%0d, need 0",
                     busy, timeout_err, overrun_cnt, audio_out, voice_sel);
        end
        @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        tests_run++;
        if (wr_cnt != base || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_quiet: got writes=%0d busy=%b, need 0 0", wr_cnt - base, busy);
        end
        run_frame("postreset");
    endtask

    initial begin
        for (int i = 0; i < NV; i++) begin
            smp[i] = 0;
            lat[i] = 1;
            noack[i] = 1'b0;
        end
        test_reset();
        test_latency();
        test_basic();
        test_saturation();
        test_sparse();
        test_random();
        test_back_to_back();
        test_overrun();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
